uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning byte width passed to the transmitter.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 64, meaning the maximum sys_clk cycles from tx_start to tx_busy rising.
REQ-004 SHALL have port sys_clk  input  1  system clock; the block has one clock.
REQ-005 SHALL have port areset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester transmit request, held until acked.
REQ-007 SHALL have port req_lock  input  NUM_REQ  per-requester "more bytes follow", keeps ownership.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_ack  output  NUM_REQ  one-cycle one-hot pulse: byte of requester i accepted.
REQ-010 SHALL have port tx_data  output  DATA_WIDTH  registered byte to the transmitter.
REQ-011 SHALL have port tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-012 SHALL have port tx_busy  input  1  transmitter busy, high for the whole frame.
REQ-013 SHALL have port owner  output  NUM_REQ  one-hot current/locked owner; zero when none.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on tx_busy timeout.

Function
REQ-016 SHALL implement states IDLE, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE, any eligible req high at a clock edge: SHALL assert tx_start, req_ack[w] and load tx_data from requester w in the following cycle, and go to WAIT_BUSY; latency 1 cycle.
REQ-018 Eligibility: when lock_q is clear all requesters are eligible; when lock_q is set only the locked owner is.
REQ-019 Winner w SHALL be the first requesting index at or after rr_ptr+1 (mod NUM_REQ); rr_ptr SHALL update to w on each grant.
REQ-020 On grant, lock_q SHALL take req_lock[w] and owner SHALL be set to one-hot w.
REQ-021 Locked owner dropping req while in IDLE SHALL clear lock_q and owner in that cycle; arbitration among all requesters resumes on the next edge.
REQ-022 WAIT_BUSY: SHALL go to WAIT_DONE on tx_busy=1; counter reaching BUSY_TIMEOUT with tx_busy=0 SHALL pulse timeout_err, clear lock_q and owner, and go to IDLE.
REQ-023 WAIT_DONE: SHALL go to IDLE on tx_busy=0; owner SHALL clear at that edge unless lock_q is set.
REQ-024 tx_data SHALL hold its value until the next grant; tx_start and req_ack SHALL never be high for more than one cycle.
REQ-025 req and data changes outside IDLE SHALL be ignored; at most one grant per transmitter frame.
REQ-026 Timeout counter SHALL be $clog2(BUSY_TIMEOUT+1) bits, cleared on entry to WAIT_BUSY, and SHALL not wrap.
REQ-027 req bits for indices >= NUM_REQ do not exist; no behaviour is defined for them.

Reset
REQ-028 areset_n low SHALL immediately force state IDLE and set req_ack, tx_data, tx_start, owner, busy and timeout_err to 0, with rr_ptr = NUM_REQ-1 and lock_q and the counter at 0.
REQ-029 Reset mid-frame SHALL abandon the frame without a timeout_err pulse; the first grant after release SHALL go to the lowest requesting index.
REQ-030 Reset deassertion SHALL take effect at the first sys_clk edge after areset_n rises; no output may pulse in that cycle.

Verification
REQ-031 Single request: req=4'b0100, data 8'hA5 -> next cycle tx_start=1, req_ack=4'b0100, tx_data=8'hA5, owner=4'b0100.
REQ-032 Round-robin: req=4'b1111 held, each frame ends correctly -> grant order 0,1,2,3,0.
REQ-033 Lock: req[1] with req_lock[1]=1 for 3 bytes, req[2] high throughout -> bytes 1,1,1, then 2 granted after lock drops.
REQ-034 Timeout: grant issued, tx_busy held 0 -> timeout_err pulses exactly 64 cycles after tx_start, then state IDLE, owner=0.
REQ-035 Reset mid-frame: areset_n low during WAIT_DONE -> all outputs 0 immediately; after release, req=4'b1010 grants index 1.
REQ-036 Locked owner drops req in IDLE with req[3] high -> lock released, index 3 granted on the following cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one UART transmitter.
// A requester can lock ownership across several bytes. A watchdog covers a transmitter that never raises tx_busy.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic                             sys_clk,
    input  logic                             areset_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic                             tx_start,
    input  logic                             tx_busy,
    output logic [NUM_REQ-1:0]               owner,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        rr_q, rr_d;
    logic                    lock_q, lock_d;
    logic [NUM_REQ-1:0]      owner_q, owner_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic                    start_q, start_d;
    logic                    terr_q, terr_d;
    logic                    busy_q, busy_d;

    logic [NUM_REQ-1:0]      elig;
    logic                    found;
    logic [PTR_W-1:0]        win_idx;
    logic [DATA_WIDTH-1:0]   win_data;
    logic                    win_lock;
    logic [NUM_REQ-1:0]      win_onehot;

    // While locked only the owner may win; otherwise everyone competes
    assign elig = lock_q ? (req & owner_q) : req;

    // Winner: smallest rotated distance from rr_q+1
    always_comb begin
        int unsigned off;
        int unsigned best_off;
        found    = 1'b0;
        win_idx  = '0;
        win_data = '0;
        win_lock = 1'b0;
        best_off = NUM_REQ;
        off      = 0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            off = (j + NUM_REQ - 32'(rr_q) - 1) % NUM_REQ;
            if (elig[j] && (off < best_off)) begin
                best_off = off;
                found    = 1'b1;
                win_idx  = PTR_W'(j);
                win_data = req_data[j*DATA_WIDTH +: DATA_WIDTH];
                win_lock = req_lock[j];
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win_idx;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        lock_d    = lock_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        ack_d     = '0;
        start_d   = 1'b0;
        terr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lock_q && ((req & owner_q) == '0)) begin
                    lock_d  = 1'b0;
                    owner_d = '0;
                end else if (found) begin
                    state_d   = WAIT_BUSY;
                    ack_d     = win_onehot;
                    start_d   = 1'b1;
                    tx_data_d = win_data;
                    rr_d      = win_idx;
                    lock_d    = win_lock;
                    owner_d   = win_onehot;
                    cnt_d     = '0;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                    lock_d  = 1'b0;
                    owner_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                    if (!lock_q) begin
                        owner_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                lock_d  = 1'b0;
                owner_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= IDLE;
            rr_q      <= PTR_W'(NUM_REQ - 1);
            lock_q    <= 1'b0;
            owner_q   <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            ack_q     <= '0;
            start_q   <= 1'b0;
            terr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
            terr_q    <= terr_d;
            busy_q    <= busy_d;
        end
    end

    assign req_ack     = ack_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = start_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scenario bench for uart_tx_arbiter: expected grants are queued as stimulus is applied.
// A negedge monitor pops them whenever tx_start fires.
module tb_uart_tx_arbiter;

    logic        sys_clk;
    logic        areset_n;
    logic [3:0]  req;
    logic [3:0]  req_lock;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [3:0]  owner;
    logic        busy;
    logic        timeout_err;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic prev_start = 1'b0;
    logic terr_allowed = 1'b0;
    logic [3:0] exp_oh;

    uart_tx_arbiter dut (
        .sys_clk     (sys_clk),
        .areset_n    (areset_n),
        .req         (req),
        .req_lock    (req_lock),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Grant monitor / scoreboard
    always @(negedge sys_clk) begin
        if (areset_n) begin
            if (timeout_err && !terr_allowed) begin
                checks++;
                errors++;
                $display("FAIL unexpected_timeout: timeout_err=1 required 0 at %0t", $time);
            end
            if (tx_start) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant: ack=%b data=%0h with no grant expected", req_ack, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    exp_oh = 4'(1) << e.idx;
                    if ({req_ack, tx_data, owner} !== {exp_oh, e.data, exp_oh}) begin
                        errors++;
                        $display("FAIL grant: ack=%b data=%0h owner=%b required ack=%b data=%0h owner=%b",
                                 req_ack, tx_data, owner, exp_oh, e.data, exp_oh);
                    end
                end
                checks++;
                if (prev_start) begin
                    errors++;
                    $display("FAIL start_width: tx_start high two cycles, required one");
                end
            end else if (req_ack !== 4'b0) begin
                checks++;
                errors++;
                $display("FAIL ack_without_start: ack=%b required 0000", req_ack);
            end
            prev_start = tx_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic push_exp(input int idx, input logic [7:0] data);
        exp_t x;
        x.idx  = idx;
        x.data = data;
        exp_q.push_back(x);
    endtask

    task automatic set_byte(input int idx, input logic [7:0] data);
        req_data[idx*8 +: 8] = data;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!tx_start && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (!tx_start) begin
            checks++;
            errors++;
            $display("FAIL %s_start_wait: tx_start=0 after %0d cycles, required 1", name, n);
        end
    endtask

    // Transmitter model: busy for n cycles, returns at the first IDLE cycle
    task automatic frame(input int n);
        tx_busy = 1'b1;
        repeat (n) @(negedge sys_clk);
        tx_busy = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        req = 4'hF;
        repeat (2) @(negedge sys_clk);
        checks++;
        if ({req_ack, tx_data, tx_start, owner, busy, timeout_err} !== 19'b0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b data=%0h start=%b owner=%b busy=%b terr=%b required all 0",
                     req_ack, tx_data, tx_start, owner, busy, timeout_err);
        end
        req = 4'h0;
        areset_n = 1'b1;
        @(negedge sys_clk);
        checks++;
        if ({req_ack, tx_start, owner, busy, timeout_err} !== 11'b0) begin
            errors++;
            $display("FAIL reset_release: ack=%b start=%b owner=%b busy=%b terr=%b required all 0",
                     req_ack, tx_start, owner, busy, timeout_err);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        logic [7:0] d[4];
        for (int i = 0; i < 4; i++) begin
            d[i] = 8'($urandom);
            set_byte(i, d[i]);
        end
        for (int k = 0; k < 5; k++) push_exp(order[k], d[order[k]]);
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_start("rr");
            if (k == 4) req = 4'h0;
            frame(2);
            checks++;
            if (owner !== 4'b0) begin
                errors++;
                $display("FAIL rr_owner_clear: owner=%b required 0000", owner);
            end
        end
    endtask

    task automatic test_single();
        set_byte(2, 8'hA5);
        push_exp(2, 8'hA5);
        req = 4'b0100;
        @(negedge sys_clk);
        checks++;
        if ({tx_start, busy, tx_data} !== {1'b1, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL single_latency: start=%b busy=%b data=%0h required 1 1 a5", tx_start, busy, tx_data);
        end
        req = 4'b0;
        set_byte(2, 8'h3C);
        frame(3);
        checks++;
        if ({tx_data, owner, busy} !== {8'hA5, 4'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_after: data=%0h owner=%b busy=%b required a5 0000 0", tx_data, owner, busy);
        end
    endtask

    task automatic test_lock();
        logic [7:0] d;
        d = 8'($urandom);
        set_byte(1, d);
        set_byte(2, 8'h77);
        push_exp(1, d);
        req = 4'b0110;
        req_lock = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            wait_start("lock");
            if (b < 2) begin
                d = 8'($urandom);
                set_byte(1, d);
                push_exp(1, d);
                if (b == 1) req_lock = 4'b0000;
            end else begin
                req = 4'b0100;
                push_exp(2, 8'h77);
            end
            frame(2);
            checks++;
            if (owner !== ((b < 2) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL lock_owner_%0d: owner=%b required %b", b, owner, (b < 2) ? 4'b0010 : 4'b0000);
            end
        end
        wait_start("lock_next");
        req = 4'b0;
        frame(2);
    endtask

    task automatic test_timeout();
        int n = 0;
        set_byte(0, 8'h5A);
        push_exp(0, 8'h5A);
        req = 4'b0001;
        req_lock = 4'b0001;
        terr_allowed = 1'b1;
        wait_start("timeout");
        req = 4'b0;
        req_lock = 4'b0;
        while (!timeout_err && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL timeout_delay: pulse %0d cycles after tx_start, required 64", n);
        end
        checks++;
        if ({owner, busy} !== 5'b0) begin
            errors++;
            $display("FAIL timeout_state: owner=%b busy=%b required 0000 0", owner, busy);
        end
        @(negedge sys_clk);
        terr_allowed = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_width: timeout_err=%b on second cycle, required 0", timeout_err);
        end
    endtask

    task automatic test_reset_midframe();
        set_byte(2, 8'hC3);
        push_exp(2, 8'hC3);
        req = 4'b0100;
        wait_start("midframe");
        req = 4'b0;
        tx_busy = 1'b1;
        repeat (2) @(negedge sys_clk);
        #2 areset_n = 1'b0;
        #1;
        checks++;
        if ({req_ack, tx_data, tx_start, owner, busy, timeout_err} !== 19'b0) begin
            errors++;
            $display("FAIL midframe_reset: ack=%b data=%0h start=%b owner=%b busy=%b terr=%b required all 0",
                     req_ack, tx_data, tx_start, owner, busy, timeout_err);
        end
        @(negedge sys_clk);
        tx_busy = 1'b0;
        @(negedge sys_clk);
        areset_n = 1'b1;
        set_byte(1, 8'h11);
        set_byte(3, 8'h33);
        push_exp(1, 8'h11);
        req = 4'b1010;
        wait_start("post_reset");
        req = 4'b0;
        frame(2);
    endtask

    task automatic test_lock_drop();
        set_byte(1, 8'h42);
        push_exp(1, 8'h42);
        req = 4'b0010;
        req_lock = 4'b0010;
        wait_start("drop");
        req = 4'b1000;
        req_lock = 4'b0000;
        set_byte(3, 8'h99);
        push_exp(3, 8'h99);
        frame(2);
        checks++;
        if (owner !== 4'b0010) begin
            errors++;
            $display("FAIL drop_locked_owner: owner=%b required 0010", owner);
        end
        @(negedge sys_clk);
        checks++;
        if ({owner, tx_start} !== 5'b0) begin
            errors++;
            $display("FAIL drop_release: owner=%b start=%b required 0000 0", owner, tx_start);
        end
        @(negedge sys_clk);
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("FAIL drop_grant: tx_start=%b required 1", tx_start);
        end
        req = 4'b0;
        frame(2);
    endtask

    initial begin
        areset_n = 1'b0;
        req      = 4'b0;
        req_lock = 4'b0;
        req_data = 32'b0;
        tx_busy  = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_lock();
        test_timeout();
        test_reset_midframe();
        test_lock_drop();
        repeat (3) @(negedge sys_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_grants: %0d expected grants not seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
